// File: rtl/rename_freelist_pkg.sv
// Shared constants and types for the rename free list.
// Tags and wrap-bit pointers are both PHY_W bits wide for the default sizing.
package rename_freelist_pkg;

  localparam int PHY_W    = 6;
  localparam int ARCH_N   = 32;
  localparam int FL_DEPTH = 32;
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int NTAG     = 1 << PHY_W;

  typedef logic [PHY_W-1:0] phy_t;
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/rename_freelist_ptr.sv
// One wrap-bit circular pointer: advances by 0/1/2 per cycle or loads a new value.
// Three instances of this module hold the spec head, the retire head and the tail.
module freelist_ptr
  import rename_freelist_pkg::*;
#(
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] inc,
  input  logic       load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  ptr_t ptr_reg;
  ptr_t ptr_next;

  always_comb begin
    ptr_next = ptr_reg + ptr_t'(inc);
    if (load) ptr_next = load_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= ptr_t'(RST_VAL);
    else     ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/rename_freelist.sv
// Dual-issue physical register free list with show-ahead allocation and recovery.
// Optional duplicate/overflow checking is compiled in with FREELIST_CHECK_EN.
module rename_freelist
  import rename_freelist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req1,
  input  logic             alloc_req2,
  output logic [PHY_W-1:0] alloc_phy1,
  output logic [PHY_W-1:0] alloc_phy2,
  output logic             alloc_stall,
  input  logic             free_en1,
  input  logic [PHY_W-1:0] free_phy1,
  input  logic             free_en2,
  input  logic [PHY_W-1:0] free_phy2,
  input  logic [1:0]       ret_cnt,
  input  logic             recover,
  output logic [PHY_W-1:0] free_count,
  output logic             fl_error
);

  phy_t entry_reg [FL_DEPTH];

  ptr_t hd, rhd, tl;
  ptr_t hd_load;
  logic [1:0] n_alloc, n_free, hd_inc;
  logic [IDX_W-1:0] hd_idx, hd_idx1, tl_idx, tl_idx1;
  logic [PHY_W:0] count_ext;
  phy_t slot_a, slot_b;

  logic we_a, we_b;
  phy_t data_a, data_b;
  logic [FL_DEPTH-1:0] sel_a, sel_b;

  assign n_alloc = {1'b0, alloc_req1} + {1'b0, alloc_req2};
  assign n_free  = {1'b0, free_en1} + {1'b0, free_en2};

  assign count_ext   = {1'b0, tl - hd};
  assign free_count  = count_ext[PHY_W-1:0];
  assign alloc_stall = (count_ext < {{(PHY_W-1){1'b0}}, n_alloc}) | recover;

  assign hd_idx  = hd[IDX_W-1:0];
  assign hd_idx1 = hd_idx + IDX_W'(1);
  assign tl_idx  = tl[IDX_W-1:0];
  assign tl_idx1 = tl_idx + IDX_W'(1);

  // Slot A always shows entry[hd]; slot B is entry[hd+1] only for a full pair.
  assign slot_a     = entry_reg[hd_idx];
  assign slot_b     = (alloc_req1 & alloc_req2) ? entry_reg[hd_idx1] : slot_a;
  assign alloc_phy1 = slot_a;
  assign alloc_phy2 = slot_b;

  assign hd_inc  = alloc_stall ? 2'd0 : n_alloc;
  assign hd_load = rhd + ptr_t'(ret_cnt);

  freelist_ptr #(.RST_VAL(0)) u_hd (
    .clk(clk), .rst(rst), .inc(hd_inc), .load(recover), .load_val(hd_load), .ptr(hd)
  );

  freelist_ptr #(.RST_VAL(0)) u_rhd (
    .clk(clk), .rst(rst), .inc(ret_cnt), .load(1'b0), .load_val('0), .ptr(rhd)
  );

  freelist_ptr #(.RST_VAL(FL_DEPTH)) u_tl (
    .clk(clk), .rst(rst), .inc(n_free), .load(1'b0), .load_val('0), .ptr(tl)
  );

  // Frees pack at the tail: a lone free_phy2 lands in the first slot.
  assign we_a   = free_en1 | free_en2;
  assign data_a = free_en1 ? free_phy1 : free_phy2;
  assign we_b   = free_en1 & free_en2;
  assign data_b = free_phy2;

  generate
    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_sel
      assign sel_a[gi] = we_a && (tl_idx  == IDX_W'(gi));
      assign sel_b[gi] = we_b && (tl_idx1 == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) entry_reg[i] <= phy_t'(ARCH_N + i);
    end else begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (sel_a[i])      entry_reg[i] <= data_a;
        else if (sel_b[i]) entry_reg[i] <= data_b;
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic [NTAG-1:0] in_list_reg, in_list_next;
  logic            err_reg, err_next;
  ptr_t            roll_len;
  logic [IDX_W-1:0] roll_idx [FL_DEPTH];
  logic [PHY_W+1:0] count_after;

  assign roll_len = hd - hd_load;

  generate
    for (genvar gi = 0; gi < FL_DEPTH; gi++) begin : g_roll
      assign roll_idx[gi] = hd_load[IDX_W-1:0] + IDX_W'(gi);
    end
  endgenerate

  // Net occupancy after this edge; above FL_DEPTH means a tag was freed twice.
  assign count_after = {2'b00, free_count} - {{PHY_W{1'b0}}, hd_inc} + {{PHY_W{1'b0}}, n_free};

  always_comb begin
    in_list_next = in_list_reg;
    if (hd_inc != 2'd0) in_list_next[slot_a] = 1'b0;
    if (hd_inc == 2'd2) in_list_next[slot_b] = 1'b0;
    if (recover) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (ptr_t'(i) < roll_len) in_list_next[entry_reg[roll_idx[i]]] = 1'b1;
      end
    end
    if (free_en1) in_list_next[free_phy1] = 1'b1;
    if (free_en2) in_list_next[free_phy2] = 1'b1;

    err_next = err_reg;
    if (free_en1 && in_list_reg[free_phy1]) err_next = 1'b1;
    if (free_en2 && in_list_reg[free_phy2]) err_next = 1'b1;
    if (we_b && (free_phy1 == free_phy2))    err_next = 1'b1;
    if (count_after > (PHY_W+2)'(FL_DEPTH))  err_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAG; i++) in_list_reg[i] <= (i >= ARCH_N);
      err_reg <= 1'b0;
    end else begin
      in_list_reg <= in_list_next;
      err_reg     <= err_next;
    end
  end

  assign fl_error = err_reg;
`else
  assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_rename_freelist.sv
// Self-checking bench: queue-based free-list model plus directed literal checks.
module tb_rename_freelist;
  import rename_freelist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic alloc_req1, alloc_req2;
  logic [PHY_W-1:0] alloc_phy1, alloc_phy2;
  logic alloc_stall;
  logic free_en1, free_en2;
  logic [PHY_W-1:0] free_phy1, free_phy2;
  logic [1:0] ret_cnt;
  logic recover;
  logic [PHY_W-1:0] free_count;
  logic fl_error;

  int total = 0;
  int bad   = 0;

  rename_freelist dut (
    .clk(clk), .rst(rst),
    .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
    .alloc_phy1(alloc_phy1), .alloc_phy2(alloc_phy2), .alloc_stall(alloc_stall),
    .free_en1(free_en1), .free_phy1(free_phy1),
    .free_en2(free_en2), .free_phy2(free_phy2),
    .ret_cnt(ret_cnt), .recover(recover),
    .free_count(free_count), .fl_error(fl_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: spec_q holds available tags in allocation order; inflight holds
  // allocated but not yet retired tags, oldest first.
  int spec_q[$];
  int inflight[$];
  logic exp_err;

  function automatic bit in_spec(input int tag);
    foreach (spec_q[i]) if (spec_q[i] == tag) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      spec_q.delete();
      inflight.delete();
      for (int i = 0; i < FL_DEPTH; i++) spec_q.push_back(ARCH_N + i);
      exp_err = 1'b0;
    end else begin
      int n, fc, taken, nf;
      bit stall;
      n     = int'(alloc_req1) + int'(alloc_req2);
      nf    = int'(free_en1) + int'(free_en2);
      fc    = spec_q.size();
      stall = (fc < n) || recover;
      taken = stall ? 0 : n;

      $display("cyc r=%0b%0b stall=%0b fc=%0d p1=%0d p2=%0d f=%0b%0b ret=%0d rec=%0b",
               alloc_req1, alloc_req2, alloc_stall, free_count, alloc_phy1, alloc_phy2,
               free_en1, free_en2, ret_cnt, recover);

      chk("stall", int'(alloc_stall), int'(stall));
      chk("free_count", int'(free_count), fc);
      chk("fl_error", int'(fl_error), int'(exp_err));
      if (!stall) begin
        if (alloc_req1 && alloc_req2) begin
          chk("phy1_pair", int'(alloc_phy1), spec_q[0]);
          chk("phy2_pair", int'(alloc_phy2), spec_q[1]);
        end else if (alloc_req1) begin
          chk("phy1_solo", int'(alloc_phy1), spec_q[0]);
        end else if (alloc_req2) begin
          chk("phy2_solo", int'(alloc_phy2), spec_q[0]);
        end
      end

`ifdef FREELIST_CHECK_EN
      if (free_en1 && in_spec(int'(free_phy1))) exp_err = 1'b1;
      if (free_en2 && in_spec(int'(free_phy2))) exp_err = 1'b1;
      if (free_en1 && free_en2 && free_phy1 == free_phy2) exp_err = 1'b1;
      if (fc - taken + nf > FL_DEPTH) exp_err = 1'b1;
`endif

      for (int i = 0; i < int'(ret_cnt); i++) void'(inflight.pop_front());
      if (recover) begin
        for (int i = inflight.size() - 1; i >= 0; i--) spec_q.push_front(inflight[i]);
        inflight.delete();
      end else begin
        for (int i = 0; i < taken; i++) inflight.push_back(spec_q.pop_front());
      end
      if (free_en1) spec_q.push_back(int'(free_phy1));
      if (free_en2) spec_q.push_back(int'(free_phy2));
    end
  end

  task automatic set_in(input logic r1, input logic r2,
                        input logic fe1, input int fp1,
                        input logic fe2, input int fp2,
                        input int rc, input logic rec);
    alloc_req1 = r1;
    alloc_req2 = r2;
    free_en1   = fe1;
    free_phy1  = PHY_W'(fp1);
    free_en2   = fe2;
    free_phy2  = PHY_W'(fp2);
    ret_cnt    = 2'(rc);
    recover    = rec;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_async_fc", int'(free_count), 32);
    chk("rst_async_err", int'(fl_error), 0);
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_fc", int'(free_count), 32);
    chk("reset_stall", int'(alloc_stall), 0);
    chk("reset_err", int'(fl_error), 0);

    // Pair allocation straight out of reset.
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("first_phy1", int'(alloc_phy1), 32);
    chk("first_phy2", int'(alloc_phy2), 33);
    chk("first_stall", int'(alloc_stall), 0);
    step();
    idle();
    #1;
    chk("after_pair_fc", int'(free_count), 30);

    // Lone req2 takes the head tag.
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("solo2_phy2", int'(alloc_phy2), 32);
    step();
    idle();
    #1;
    chk("solo2_fc", int'(free_count), 31);

    // Drain to empty, stall, and allocate a tag freed during the stall.
    do_reset();
    repeat (16) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      step();
    end
    set_in(1, 0, 1, 5, 0, 0, 0, 0);
    #1;
    chk("empty_fc", int'(free_count), 0);
    chk("empty_stall", int'(alloc_stall), 1);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("refill_phy1", int'(alloc_phy1), 5);
    chk("refill_stall", int'(alloc_stall), 0);
    step();
    idle();

    // Allocate six tags, retire one while recovering.
    do_reset();
    repeat (3) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("recover_stall", int'(alloc_stall), 1);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("recover_phy1", int'(alloc_phy1), 33);
    chk("recover_fc", int'(free_count), 31);
    step();
    idle();

    // Steady allocate-2/free-2 across pointer wrap.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      set_in(1, 1, 1, (2 * k) % 64, 1, (2 * k + 1) % 64, (k > 0) ? 2 : 0, 0);
      #1;
      if (k == 16) begin
        chk("wrap16_phy1", int'(alloc_phy1), 0);
        chk("wrap16_phy2", int'(alloc_phy2), 1);
      end
      if (k == 39) begin
        chk("wrap39_phy1", int'(alloc_phy1), 46);
        chk("wrap39_phy2", int'(alloc_phy2), 47);
      end
      step();
    end
    idle();
    #1;
    chk("wrap_fc", int'(free_count), 32);

`ifdef FREELIST_CHECK_EN
    // Freeing a tag that is still listed raises the sticky error.
    do_reset();
    set_in(0, 0, 1, 40, 0, 0, 0, 0);
    step();
    idle();
    #1;
    chk("dup_err_set", int'(fl_error), 1);
    repeat (3) step();
    chk("dup_err_sticky", int'(fl_error), 1);
    do_reset();
    chk("dup_err_cleared", int'(fl_error), 0);
`else
    chk("err_tied_low", int'(fl_error), 0);
`endif

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
